// File: rtl/snow64_instr_fetch_pkg.sv
// Shared types and helpers for the snow64 instruction fetch stage.
// Address/line typedefs, fetch states and cache-port bundles.
package PkgSnow64InstrFetch;

  localparam int WIDTH__INSTR        = 32;
  localparam int NUM_INSTRS_PER_LINE = 8;
  localparam int WIDTH__LINE_OFFSET  = 5;

  typedef logic [63:0]  CpuAddr;
  typedef logic [255:0] LarData;
  typedef logic [WIDTH__INSTR-1:0] Instr;
  typedef logic [63-WIDTH__LINE_OFFSET:0] LineTag;
  typedef logic [2:0]   LineWordIndex;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    SUPPLY
  } StInstrFetch;

  typedef struct packed {
    logic   valid;
    LarData data;
  } PortIn_InstrFetch;

  typedef struct packed {
    logic   req;
    CpuAddr addr;
  } PortOut_InstrFetch;

  function automatic CpuAddr lineAddr(CpuAddr a);
    return {a[63:WIDTH__LINE_OFFSET],
            {WIDTH__LINE_OFFSET{1'b0}}};
  endfunction

  function automatic CpuAddr wordAlign(CpuAddr a);
    return {a[63:2], 2'b00};
  endfunction

  function automatic LineTag tagOf(CpuAddr a);
    return a[63:WIDTH__LINE_OFFSET];
  endfunction

endpackage

// File: rtl/snow64_instr_fetch_line_select.sv
// Picks one 32-bit instruction out of a buffered 256-bit line.
// Word 0 sits in bits 31:0.
module snow64_instr_fetch_line_select
  import PkgSnow64InstrFetch::*;
(
  input  LarData       line,
  input  LineWordIndex idx,
  output Instr         word
);

  Instr [NUM_INSTRS_PER_LINE-1:0] words;

  assign words = line;
  assign word  = words[idx];

endmodule

// File: rtl/snow64_instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches whole lines from the
// icache and streams 32-bit words to decode with valid/ready.
module snow64_instr_fetch #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int          WIDTH__ADDR  = 64,
  parameter int          WIDTH__LINE  = 256,
  parameter int          WIDTH__INSTR = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_cache_valid,
  input  logic [WIDTH__LINE-1:0]  in_cache_data,
  output logic                    out_cache_req,
  output logic [WIDTH__ADDR-1:0]  out_cache_addr,
  input  logic                    in_branch_valid,
  input  logic [WIDTH__ADDR-1:0]  in_branch_target,
  input  logic                    in_decode_ready,
  output logic                    out_instr_valid,
  output logic [WIDTH__INSTR-1:0] out_instr,
  output logic [WIDTH__ADDR-1:0]  out_instr_pc
);
  import PkgSnow64InstrFetch::*;

  localparam CpuAddr ResetPc = wordAlign(RESET_PC);

  StInstrFetch       state;
  CpuAddr            pc;
  logic              squash;
  logic              tagValid;
  LineTag            tag;
  LarData            line;
  PortIn_InstrFetch  cacheIn;
  PortOut_InstrFetch cacheOut;

  CpuAddr target;
  CpuAddr nextPc;
  logic   accept;
  logic   sameLine;
  logic   leaveLine;
  LarData selLine;
  Instr   selWord;

  assign cacheIn = {in_cache_valid, in_cache_data};
  assign out_cache_req  = cacheOut.req;
  assign out_cache_addr = cacheOut.addr;

  assign target   = in_branch_target & ~CpuAddr'(3);
  assign accept   = out_instr_valid & in_decode_ready;
  assign sameLine = tagValid && (tagOf(target) == tag);

  // Branch wins over accept: a consumed word is replaced by the target.
  always_comb begin
    nextPc = pc;
    if (in_branch_valid)
      nextPc = target;
    else if (accept)
      nextPc = pc + 64'd4;
  end

  always_comb begin
    leaveLine = 1'b0;
    if (in_branch_valid)
      leaveLine = !sameLine;
    else if (accept)
      leaveLine = (pc[4:2] == 3'd7);
  end

  // While a line lands, decode sees it straight from the cache bus.
  assign selLine = (state == WAIT) ? cacheIn.data : line;

  snow64_instr_fetch_line_select u_lineSelect (
    .line(selLine),
    .idx (nextPc[4:2]),
    .word(selWord)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= REQ;
      pc              <= ResetPc;
      squash          <= 1'b0;
      tagValid        <= 1'b0;
      tag             <= '0;
      line            <= '0;
      cacheOut        <= '{req: 1'b0, addr: lineAddr(RESET_PC)};
      out_instr_valid <= 1'b0;
      out_instr       <= '0;
      out_instr_pc    <= ResetPc;
    end else begin
      cacheOut.req <= 1'b0;
      pc           <= nextPc;
      unique case (state)
        REQ: begin
          cacheOut.req  <= 1'b1;
          cacheOut.addr <= lineAddr(pc);
          if (in_branch_valid)
            squash <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (cacheIn.valid) begin
            squash <= 1'b0;
            if (squash || in_branch_valid) begin
              state <= REQ;
            end else begin
              state           <= SUPPLY;
              line            <= cacheIn.data;
              tag             <= tagOf(pc);
              tagValid        <= 1'b1;
              out_instr_valid <= 1'b1;
              out_instr       <= selWord;
              out_instr_pc    <= pc;
            end
          end else if (in_branch_valid) begin
            squash <= 1'b1;
          end
        end
        SUPPLY: begin
          if (leaveLine) begin
            state           <= REQ;
            out_instr_valid <= 1'b0;
            if (in_branch_valid)
              tagValid <= 1'b0;
          end else begin
            out_instr    <= selWord;
            out_instr_pc <= nextPc;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_instr_fetch.sv
// Self-checking bench for snow64_instr_fetch: directed scenarios plus
// random decode/branch/cache-latency traffic against a PC-stream model.
module tb_snow64_instr_fetch;

  localparam logic [63:0] RPC = 64'h100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_cache_valid = 1'b0;
  logic [255:0] in_cache_data = '0;
  logic         out_cache_req;
  logic [63:0]  out_cache_addr;
  logic         in_branch_valid = 1'b0;
  logic [63:0]  in_branch_target = '0;
  logic         in_decode_ready = 1'b0;
  logic         out_instr_valid;
  logic [31:0]  out_instr;
  logic [63:0]  out_instr_pc;

  int nCmp = 0;
  int nBad = 0;

  logic [63:0] expPc;
  logic [63:0] reqAddr;
  logic        pend;
  logic        stale;
  logic        respNow;
  logic        randLat;
  int          cnt;
  int          nInstr;

  snow64_instr_fetch #(.RESET_PC(RPC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_cache_valid  (in_cache_valid),
    .in_cache_data   (in_cache_data),
    .out_cache_req   (out_cache_req),
    .out_cache_addr  (out_cache_addr),
    .in_branch_valid (in_branch_valid),
    .in_branch_target(in_branch_target),
    .in_decode_ready (in_decode_ready),
    .out_instr_valid (out_instr_valid),
    .out_instr       (out_instr),
    .out_instr_pc    (out_instr_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Memory image: word at byte address a is 0xA0 + (a - RESET_PC)/4.
  function automatic logic [31:0] memWord(input logic [63:0] a);
    logic [63:0] d;
    d = ((a - RPC) >> 2) + 64'hA0;
    return d[31:0];
  endfunction

  function automatic logic [255:0] lineOf(input logic [63:0] a);
    logic [255:0] l;
    logic [63:0]  b;
    b = {a[63:5], 5'b0};
    for (int i = 0; i < 8; i++)
      l[i*32 +: 32] = memWord(b + 64'(i * 4));
    return l;
  endfunction

  // One clock: drive inputs at negedge, sample and check at next negedge.
  task automatic tick(input logic rdy, input logic br,
                      input logic [63:0] tgt);
    logic prevValid;
    prevValid        = out_instr_valid;
    in_decode_ready  = rdy;
    in_branch_valid  = br;
    in_branch_target = tgt;
    in_cache_valid   = 1'b0;
    in_cache_data    = {8{$urandom}};
    respNow          = 1'b0;
    if (pend) begin
      if (br) stale = 1'b1;
      cnt--;
      if (cnt == 0) begin
        in_cache_valid = 1'b1;
        in_cache_data  = lineOf(reqAddr);
        respNow        = 1'b1;
      end
    end
    @(negedge clk);
    if (br)
      expPc = tgt & ~64'h3;
    else if (prevValid && rdy)
      expPc = expPc + 64'd4;
    if (out_instr_valid) begin
      nInstr++;
      chk("pc", out_instr_pc, expPc);
      chk("instr", out_instr, memWord(expPc));
    end
    if (prevValid && !rdy && !br)
      chk("hold", out_instr_valid, 1);
    if (respNow) begin
      chk(stale ? "squash" : "latency", out_instr_valid, !stale);
      pend = 1'b0;
    end
    if (out_cache_req) begin
      chk("align", out_cache_addr[4:0], 0);
      chk("outstanding", pend, 0);
      if (!br) chk("reqaddr", out_cache_addr, expPc & ~64'h1F);
      pend    = 1'b1;
      stale   = br;
      cnt     = randLat ? $urandom_range(1, 4) : 2;
      reqAddr = out_cache_addr;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n           = 1'b0;
    in_cache_valid  = 1'b0;
    in_branch_valid = 1'b0;
    in_decode_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pend  = 1'b0;
    stale = 1'b0;
    expPc = RPC;
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (!out_instr_valid && n < 30) begin
      tick(1'b1, 1'b0, '0);
      n++;
    end
    chk(tag, out_instr_valid, 1);
  endtask

  task automatic waitReq(input string tag, input logic [63:0] exp);
    int n = 0;
    while (!out_cache_req && n < 30) begin
      tick(1'b1, 1'b0, '0);
      n++;
    end
    chk({tag, "_req"}, out_cache_req, 1);
    chk({tag, "_addr"}, out_cache_addr, exp);
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_req"}, out_cache_req, 0);
    chk({tag, "_addr"}, out_cache_addr, RPC & ~64'h1F);
    chk({tag, "_valid"}, out_instr_valid, 0);
    chk({tag, "_instr"}, out_instr, 0);
    chk({tag, "_pc"}, out_instr_pc, RPC & ~64'h3);
  endtask

  initial begin
    pend = 1'b0; stale = 1'b0; respNow = 1'b0;
    randLat = 1'b0; expPc = RPC; cnt = 0; nInstr = 0;
    repeat (2) @(negedge clk);
    chkReset("rst");
    rst_n = 1'b1;

    tick(1'b1, 1'b0, '0);
    chk("a_req", out_cache_req, 1);
    chk("a_addr", out_cache_addr, 64'h100);
    tick(1'b1, 1'b0, '0);
    chk("a_wait", out_instr_valid, 0);
    tick(1'b1, 1'b0, '0);
    chk("a_first", out_instr_valid, 1);
    chk("a_first_pc", out_instr_pc, 64'h100);
    for (int i = 1; i < 8; i++) begin
      tick(1'b1, 1'b0, '0);
      chk("a_stream", out_instr_valid, 1);
      chk("a_word", out_instr, 32'hA0 + 32'(i));
      chk("a_noreq", out_cache_req, 0);
    end
    tick(1'b1, 1'b0, '0);
    chk("a_cross", out_instr_valid, 0);
    tick(1'b1, 1'b0, '0);
    chk("a_req2", out_cache_req, 1);
    chk("a_addr2", out_cache_addr, 64'h120);

    doReset();
    waitValid("b_valid");
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    chk("b_pc", out_instr_pc, 64'h108);
    repeat (3) begin
      tick(1'b0, 1'b0, '0);
      chk("b_stall_pc", out_instr_pc, 64'h108);
      chk("b_stall_req", out_cache_req, 0);
    end
    tick(1'b1, 1'b0, '0);
    chk("b_next_pc", out_instr_pc, 64'h10C);

    doReset();
    waitValid("c_valid");
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 64'h114);
    chk("c_valid2", out_instr_valid, 1);
    chk("c_pc", out_instr_pc, 64'h114);
    chk("c_instr", out_instr, 32'hA5);
    repeat (3) begin
      chk("c_noreq", out_cache_req, 0);
      tick(1'b1, 1'b0, '0);
    end

    doReset();
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b1, 64'h2002);
    waitReq("d", 64'h2000);
    waitValid("d_valid");
    chk("d_pc", out_instr_pc, 64'h2000);

    doReset();
    waitValid("e_valid");
    tick(1'b1, 1'b1, 64'h400);
    chk("e_drop", out_instr_valid, 0);
    waitReq("e", 64'h400);
    waitValid("e_valid2");
    chk("e_pc", out_instr_pc, 64'h400);

    doReset();
    tick(1'b0, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    chkReset("f_rst");
    @(negedge clk);
    rst_n = 1'b1;
    pend = 1'b0; stale = 1'b0; expPc = RPC;
    in_cache_valid = 1'b1;
    in_cache_data  = {8{32'hDEAD_BEEF}};
    @(negedge clk);
    in_cache_valid = 1'b0;
    chk("f_ignore", out_instr_valid, 0);
    chk("f_req", out_cache_req, 1);
    chk("f_addr", out_cache_addr, RPC);
    pend = 1'b1; cnt = 2; reqAddr = out_cache_addr;
    waitValid("f_valid");
    chk("f_pc", out_instr_pc, RPC);

    doReset();
    randLat = 1'b1;
    nInstr  = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        rdy;
      logic        br;
      logic [63:0] tgt;
      logic [4:0]  off;
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 15) == 0);
      off = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0, 1:    tgt = {expPc[63:5], off};
        2:       tgt = 64'h1000 + 64'($urandom_range(0, 7)) * 64'd32
                       + 64'(off);
        default: tgt = 64'hFFFF_FFFF_FFFF_FFC0
                       + 64'($urandom_range(0, 63));
      endcase
      tick(rdy, br, tgt);
    end
    chk("progress", 64'(nInstr > 300), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
